// File: rtl/instr_decode_pkg.sv
// Shared opcode definitions for the instruction decode queue.
// Opcodes outside the defined set are treated as illegal.
package instr_decode_pkg;

    localparam logic [3:0] OP_POS     = 4'h0;
    localparam logic [3:0] OP_SPRMEM  = 4'h1;
    localparam logic [3:0] OP_OFFSET  = 4'h2;
    localparam logic [3:0] OP_BGCOLOR = 4'h3;

    function automatic logic is_legal_op(input logic [31:0] op);
        return op <= 32'(OP_BGCOLOR);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous show-ahead FIFO; head holds the last popped word when empty.
// Push is refused while full even if a pop happens in the same cycle.
module instr_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [W-1:0]  last;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            last  <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            if (do_pop) begin
                rptr <= rptr + 1'b1;
                last <= mem[rptr];
            end
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= wdata;
    end

    assign rdata = empty ? last : mem[rptr];

endmodule

// File: rtl/instr_decode_queue.sv
// Decodes custom-instruction words and queues them for the control unit.
// Illegal opcodes are never queued; drops and illegal opcodes raise sticky flags.
module instr_decode_queue
    import instr_decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 17,
    parameter int IDX_W  = 5,
    parameter int OP_W   = 4,
    parameter int DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_en,
    input  logic [31:0]            dataA,
    input  logic [DATA_W-1:0]      dataB,
    input  logic                   out_ready,
    input  logic                   clear_flags,
    output logic                   out_valid,
    output logic [OP_W-1:0]        out_opcode,
    output logic [REG_W-1:0]       out_register,
    output logic [DATA_W-1:0]      out_data,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   illegal
);

    localparam int EW = OP_W + REG_W + DATA_W;

    function automatic logic [REG_W-1:0] decode_reg(input logic [31:0] a);
        logic [31:0] o;
        o = 32'(a[OP_W-1:0]);
        decode_reg = '0;
        unique case (1'b1)
            o == 32'(OP_POS),
            o == 32'(OP_OFFSET): decode_reg = REG_W'(a[IDX_W+OP_W-1:OP_W]);
            o == 32'(OP_SPRMEM): decode_reg = a[REG_W+OP_W-1:OP_W];
            default:             decode_reg = '0;
        endcase
    endfunction

    logic [OP_W-1:0] opcode;
    logic            legal;
    logic            push;
    logic            empty;
    logic            ovf_evt;
    logic            ill_evt;
    logic [EW-1:0]   wdata;
    logic [EW-1:0]   head;
    logic            unused_dataa;

    assign opcode       = dataA[OP_W-1:0];
    assign legal        = is_legal_op(32'(opcode));
    assign push         = clk_en & legal;
    assign wdata        = {opcode, decode_reg(dataA), dataB};
    assign unused_dataa = ^dataA;

    // Space is judged on the registered full only, so a same-cycle pop never rescues a push.
    assign ovf_evt = push & full;
    assign ill_evt = clk_en & ~legal;

    instr_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (out_ready),
        .wdata (wdata),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign out_valid = ~empty;
    assign {out_opcode, out_register, out_data} = head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            overflow <= ovf_evt | (overflow & ~clear_flags);
            illegal  <= ill_evt | (illegal & ~clear_flags);
        end
    end

endmodule

// File: tb/tb_instr_decode_queue.sv
// Randomised and directed bench for instr_decode_queue against a queue model.
// Expected values come from the decode rules applied to a plain SV queue.
module tb_instr_decode_queue;

    localparam int DATA_W = 32;
    localparam int REG_W  = 17;
    localparam int IDX_W  = 5;
    localparam int OP_W   = 4;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              clk_en = 1'b0;
    logic [31:0]       dataA = '0;
    logic [DATA_W-1:0] dataB = '0;
    logic              out_ready = 1'b0;
    logic              clear_flags = 1'b0;
    logic              out_valid;
    logic [OP_W-1:0]   out_opcode;
    logic [REG_W-1:0]  out_register;
    logic [DATA_W-1:0] out_data;
    logic              full;
    logic [3:0]        level;
    logic              overflow;
    logic              illegal;

    instr_decode_queue #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .IDX_W  (IDX_W),
        .OP_W   (OP_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clk_en       (clk_en),
        .dataA        (dataA),
        .dataB        (dataB),
        .out_ready    (out_ready),
        .clear_flags  (clear_flags),
        .out_valid    (out_valid),
        .out_opcode   (out_opcode),
        .out_register (out_register),
        .out_data     (out_data),
        .full         (full),
        .level        (level),
        .overflow     (overflow),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [16:0] r;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    ent_t last;
    bit   m_ovf;
    bit   m_ill;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ent_t ref_decode(input logic [31:0] a,
                                        input logic [31:0] b);
        ent_t e;
        e.op = 4'(a % 16);
        e.d  = b;
        case (e.op)
            4'd0, 4'd2: e.r = 17'((a / 16) % 32);
            4'd1:       e.r = 17'((a / 16) % 131072);
            default:    e.r = '0;
        endcase
        return e;
    endfunction

    task automatic model_reset();
        q.delete();
        last  = '{op: '0, r: '0, d: '0};
        m_ovf = 0;
        m_ill = 0;
    endtask

    task automatic check_all(input string ph);
        ent_t h;
        h = (q.size() != 0) ? q[0] : last;
        chk({ph, ".valid"},    out_valid, q.size() != 0);
        chk({ph, ".opcode"},   out_opcode, h.op);
        chk({ph, ".register"}, out_register, h.r);
        chk({ph, ".data"},     out_data, h.d);
        chk({ph, ".full"},     full, q.size() == DEPTH);
        chk({ph, ".level"},    level, q.size());
        chk({ph, ".overflow"}, overflow, m_ovf);
        chk({ph, ".illegal"},  illegal, m_ill);
    endtask

    task automatic step(input string ph);
        bit was_full, was_valid, lg, ill;
        @(posedge clk);
        if (reset) begin
            was_full  = (q.size() == DEPTH);
            was_valid = (q.size() != 0);
            lg  = clk_en && (dataA % 16 < 4);
            ill = clk_en && (dataA % 16 >= 4);
            if (was_valid && out_ready)
                last = q.pop_front();
            if (lg && !was_full)
                q.push_back(ref_decode(dataA, dataB));
            m_ovf = (lg && was_full) || (m_ovf && !clear_flags);
            m_ill = ill || (m_ill && !clear_flags);
        end
        #1;
        check_all(ph);
    endtask

    task automatic set_in(input bit ce, input logic [31:0] a,
                          input logic [31:0] b, input bit rdy, input bit clr);
        clk_en      = ce;
        dataA       = a;
        dataB       = b;
        out_ready   = rdy;
        clear_flags = clr;
    endtask

    task automatic async_reset(input string ph);
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk({ph, ".rst_level"}, level, 0);
        chk({ph, ".rst_valid"}, out_valid, 0);
        check_all(ph);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        model_reset();
        set_in(1, 32'h0000_0151, 32'hDEAD_BEEF, 1, 0);
        repeat (3) step("reset");
        @(negedge clk);
        reset = 1'b1;

        set_in(1, 32'h0000_0150, 32'h0064_00C8, 0, 0);
        step("pos");
        chk("pos.reg_0x15", out_register, 17'h00015);
        set_in(0, 0, 0, 1, 0);
        step("pos_pop");

        for (int i = 0; i < 8; i++) begin
            set_in(1, (i << 4) | 1, 32'h1000 + i, 0, 0);
            step("fill");
        end
        set_in(1, (8 << 4) | 1, 32'h1008, 0, 0);
        step("drop9");
        chk("drop9.overflow", overflow, 1);
        for (int i = 0; i < 9; i++) begin
            set_in(0, 0, 0, 1, 0);
            step("drain");
        end
        set_in(0, 0, 0, 0, 1);
        step("clr_ovf");

        set_in(1, 32'h0000_0AB9, 32'h5, 0, 0);
        step("illegal");
        chk("illegal.flag", illegal, 1);
        set_in(0, 0, 0, 0, 1);
        step("clr_ill");

        for (int i = 0; i < 3; i++) begin
            set_in(1, (i << 4) | 2, 32'h2000 + i, 0, 0);
            step("pre3");
        end
        for (int i = 0; i < 10; i++) begin
            set_in(1, ((i + 3) << 4) | 1, 32'h3000 + i, 1, 0);
            step("steady");
        end
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, 1, 0);
            step("drain3");
        end

        for (int i = 0; i < 8; i++) begin
            set_in(1, (i << 4) | 3, 32'h4000 + i, 0, 1);
            step("fill2");
        end
        set_in(1, 32'h0000_0071, 32'h4444, 1, 0);
        step("full_pp");
        chk("full_pp.level7", level, 7);
        set_in(1, 32'h0000_0021, 32'h5555, 0, 0);
        async_reset("arst");

        for (int n = 0; n < 1500; n++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0)
                a[3:0] = 4'($urandom_range(4, 15));
            else
                a[3:0] = 4'($urandom_range(0, 3));
            set_in($urandom_range(0, 2) != 0, a, $urandom,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
            step("rand");
            if ($urandom_range(0, 199) == 0)
                async_reset("rand_rst");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_decode_queue.md
Name: instr_decode_queue

Overview:
- Parametrised successor to the video-processor instruction decoder.
- Accepts instruction words from the processor custom-instruction interface (dataA/dataB plus strobe) and decodes opcode/register/data fields.
- Buffers decoded instructions in a DEPTH-entry FIFO and presents them to the control unit through a valid/ready handshake.
- Replaces the single-slot "new_instruction" hold with real back-pressure, overflow detection and illegal-opcode detection.

Parameters:
- DATA_W, 32, width of data field (dataB and out_data).
- REG_W, 17, width of decoded register/address field; must be at most 28.
- IDX_W, 5, width of register-bank index for opcodes 0 and 2; must be less than REG_W.
- OP_W, 4, opcode field width (dataA[OP_W-1:0]).
- DEPTH, 8, FIFO entries; power of two, at least 2.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous active-low reset.
- clk_en, input, 1, new instruction strobe; one instruction per cycle while high.
- dataA, input, 32, opcode in [OP_W-1:0], operands above.
- dataB, input, DATA_W, data operand.
- out_ready, input, 1, control unit accepts head entry.
- clear_flags, input, 1, clears sticky flags.
- out_valid, output, 1, head entry valid.
- out_opcode, output, OP_W, head opcode.
- out_register, output, REG_W, head register/address.
- out_data, output, DATA_W, head data.
- full, output, 1, FIFO holds DEPTH entries.
- level, output, $clog2(DEPTH)+1, current occupancy.
- overflow, output, 1, sticky: a legal instruction was dropped because the FIFO was full.
- illegal, output, 1, sticky: an undefined opcode was received.

Behaviour:
- Reset is asynchronous, active-low, on clock clk. While reset is low:
  - pointers and level = 0; out_valid = 0; full = 0;
  - out_opcode, out_register and out_data = 0; overflow and illegal = 0.
  - No X is ever driven.
- Reset mid-operation discards all queued entries.
- Decode is combinational on (dataA, dataB), sampled only when clk_en = 1:
  - opcode 0 (POS): register = zero-extended dataA[IDX_W+OP_W-1:OP_W]; data = dataB.
  - opcode 1 (SPRMEM): register = dataA[REG_W+OP_W-1:OP_W]; data = dataB.
  - opcode 2 (OFFSET): register = zero-extended dataA[IDX_W+OP_W-1:OP_W]; data = dataB.
  - opcode 3 (BGCOLOR): register = 0; data = dataB.
  - any other opcode is illegal: it is not enqueued, and illegal is set on the next edge.
- Push occurs when clk_en = 1, the opcode is legal and full = 0 as registered at the start of the cycle.
  - A pop in the same cycle does not free space for that push.
  - A legal instruction arriving while full is dropped, and overflow is set.
- Pop occurs when out_valid = 1 and out_ready = 1; the read pointer advances on that edge.
- Output is show-ahead:
  - out_opcode, out_register and out_data always reflect the head entry.
  - When empty they hold the last popped values (0 after reset).
  - out_ready is ignored while out_valid = 0.
- Latency: an instruction strobed at edge N appears with out_valid = 1 after edge N; no bypass from the strobe to the outputs.
- Simultaneous push and pop (not full): level is unchanged; both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. full = (level == DEPTH); out_valid = (level != 0).
- Sticky flags: clear_flags = 1 clears overflow and illegal on the next edge. If a new overflow or illegal event occurs in the same cycle, set wins.
- Entry ordering is strictly FIFO; there is no reordering or merging of instructions.

Decomposition:
- Package instr_decode_pkg holds:
  - localparams OP_POS = 4'h0, OP_SPRMEM = 4'h1, OP_OFFSET = 4'h2, OP_BGCOLOR = 4'h3;
  - function is_legal_op.
- The decode function stays inside instr_decode_queue.
- One sub-module, instr_fifo: a synchronous show-ahead FIFO, parametrised on width and DEPTH, with push, pop, full, level and head-data outputs. Entry width = OP_W + REG_W + DATA_W.

Test Plan:
- Reset with clk_en = 1 and a legal opcode → out_valid = 0, outputs 0, level = 0, flags 0.
- Strobe dataA = 0x0000_0150 (POS, idx 0x15), dataB = 0x0064_00C8, out_ready = 0 → next cycle: out_valid = 1, out_opcode = 0, out_register = 0x00015, out_data = 0x006400C8, level = 1.
- Push 8 SPRMEM instructions with register = 0..7 and out_ready = 0 → full = 1, level = 8. A 9th strobe is dropped and overflow = 1. Then out_ready = 1 → registers pop in order 0..7, then out_valid = 0.
- Strobe opcode 0x9 → not queued, level unchanged, illegal = 1. Then clear_flags = 1 → illegal = 0 next cycle.
- Steady state with level = 3: push and pop in the same cycle for 10 cycles → level stays 3, FIFO order preserved, pointers wrap.
- While full, assert push and pop in the same cycle → push dropped, overflow = 1, level = 7. Assert reset asynchronously mid-stream → level = 0 and out_valid = 0 immediately.
